// File: rtl/hash_jtree_stream.sv
// Elastic sample-jitter stage: XOR-fold hash of each sample position is masked
// by the MSAA mode and ORed into the sub-pixel bits, then carried through a valid/ready pipeline.
module hash_jtree_stream #(
  parameter int SIGFIG      = 24,
  parameter int RADIX       = 10,
  parameter int VERTS       = 3,
  parameter int AXIS        = 3,
  parameter int COLORS      = 3,
  parameter int NUM_SAMPLES = 4,
  parameter int PIPE_DEPTH  = 3
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid_R14H,
  output logic                                          in_ready_R14H,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  input  logic [COLORS-1:0][SIGFIG-1:0]                 color_R14U,
  input  logic signed [NUM_SAMPLES-1:0][1:0][SIGFIG-1:0] sample_R14S,
  input  logic [NUM_SAMPLES-1:0]                        validSamp_R14H,
  input  logic [3:0]                                    subSample_RnnnnU,
  input  logic                                          jitterEn_RnnnnH,
  output logic                                          out_valid_R16H,
  input  logic                                          out_ready_R16H,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
  output logic [COLORS-1:0][SIGFIG-1:0]                 color_R16U,
  output logic signed [NUM_SAMPLES-1:0][1:0][SIGFIG-1:0] sample_R16S,
  output logic [NUM_SAMPLES-1:0]                        validSamp_R16H,
  output logic                                          modeErr_RnnnnH
);

  localparam int W   = RADIX - 2;
  localparam int HW  = 2 * (SIGFIG - 4);
  localparam int NCH = (HW + W - 1) / W;
  localparam int PW  = NCH * W;

  typedef struct packed {
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_s;
    logic [COLORS-1:0][SIGFIG-1:0]           color_u;
    logic [NUM_SAMPLES-1:0][1:0][SIGFIG-1:0] samp_s;
    logic [NUM_SAMPLES-1:0]                  vs;
  } pay_t;

  // Handshake: a stage transfers on an edge where its valid and the downstream
  // ready are both high; a stage with a held item never changes until it transfers.
  logic [PIPE_DEPTH-1:0]        v_q, v_d;
  pay_t [PIPE_DEPTH-1:0]        pay_q, pay_d;
  logic                         mode_err_q, mode_err_d;
  logic [PIPE_DEPTH-1:0]        rdy;
  logic [W-1:0]                 mask;
  logic                         mode_ok;
  logic [NUM_SAMPLES-1:0][1:0][SIGFIG-1:0] jit;
  pay_t                         stage_in;

  function automatic logic [W-1:0] fold(input logic [SIGFIG-5:0] lo,
                                        input logic [SIGFIG-5:0] hi);
    logic [PW-1:0] h;
    h         = '0;
    h[HW-1:0] = {hi, lo};
    fold      = '0;
    for (int k = 0; k < NCH; k++) fold = fold ^ h[k*W +: W];
  endfunction

  always_comb begin
    mask    = '0;
    mode_ok = 1'b1;
    case (subSample_RnnnnU)
      4'b1000: mask = {W{1'b1}};
      4'b0100: mask = {W{1'b1}} >> 1;
      4'b0010: mask = {W{1'b1}} >> 2;
      4'b0001: mask = {W{1'b1}} >> 3;
      default: mode_ok = 1'b0;
    endcase
  end

  // x folds {y,x} and y folds {x,y}; only the jitter field [RADIX-1:2] is touched.
  always_comb begin
    jit = sample_R14S;
    if (jitterEn_RnnnnH) begin
      for (int i = 0; i < NUM_SAMPLES; i++) begin
        jit[i][0][RADIX-1:2] = sample_R14S[i][0][RADIX-1:2] |
          (fold(sample_R14S[i][0][SIGFIG-1:4], sample_R14S[i][1][SIGFIG-1:4]) & mask);
        jit[i][1][RADIX-1:2] = sample_R14S[i][1][RADIX-1:2] |
          (fold(sample_R14S[i][1][SIGFIG-1:4], sample_R14S[i][0][SIGFIG-1:4]) & mask);
      end
    end
  end

  assign stage_in = '{tri_s: tri_R14S, color_u: color_R14U, samp_s: jit, vs: validSamp_R14H};

  // Stage k can load if it or any stage after it is empty, or the sink is ready.
  always_comb begin
    rdy = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      rdy[k] = out_ready_R16H;
      for (int j = k; j < PIPE_DEPTH; j++) begin
        if (!v_q[j]) rdy[k] = 1'b1;
      end
    end
  end

  always_comb begin
    v_d        = v_q;
    pay_d      = pay_q;
    mode_err_d = mode_err_q;
    if (rdy[0]) v_d[0] = in_valid_R14H;
    if (rdy[0] && in_valid_R14H) begin
      pay_d[0] = stage_in;
      if (!mode_ok) mode_err_d = 1'b1;
    end
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      if (rdy[k]) v_d[k] = v_q[k-1];
      if (rdy[k] && v_q[k-1]) pay_d[k] = pay_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q        <= '0;
      pay_q      <= '0;
      mode_err_q <= 1'b0;
    end else begin
      v_q        <= v_d;
      pay_q      <= pay_d;
      mode_err_q <= mode_err_d;
    end
  end

  assign in_ready_R14H  = rdy[0];
  assign out_valid_R16H = v_q[PIPE_DEPTH-1];
  assign tri_R16S       = pay_q[PIPE_DEPTH-1].tri_s;
  assign color_R16U     = pay_q[PIPE_DEPTH-1].color_u;
  assign sample_R16S    = pay_q[PIPE_DEPTH-1].samp_s;
  assign validSamp_R16H = pay_q[PIPE_DEPTH-1].vs;
  assign modeErr_RnnnnH = mode_err_q;

endmodule
